// File: rtl/percept_mac_serial.sv
// Serial perceptron MAC: shifts in weight then data, executes opcode on acc.
// Define PERCEPT_SAT_EN to saturate acc on ADD/SUB/MAC overflow instead of wrapping.
module percept_mac_serial #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_vld,
    input  logic [2:0]           opcode,
    output logic                 tx,
    output logic                 tx_vld,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT_W   = 3'd1;
    localparam logic [2:0] S_SHIFT_D   = 3'd2;
    localparam logic [2:0] S_EXEC      = 3'd3;
    localparam logic [2:0] S_SHIFT_OUT = 3'd4;

    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_MAC  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_ACT  = 3'd5;
    localparam logic [2:0] OP_READ = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    localparam int CW = $clog2(ACC_WIDTH + 1);
    localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] A_LAST = CW'(ACC_WIDTH - 1);
    localparam int XW = ACC_WIDTH + 1;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     w_q, w_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] sh_q, sh_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   w_ext, d_ext, prod;
    logic [XW-1:0]        acc_x, prod_x, d_x, sum_x;
    logic [ACC_WIDTH-1:0] res;
    logic                 arith, ovf_hit;

    function automatic logic [WIDTH-1:0] shin(input logic [WIDTH-1:0] v, input logic b);
        return MSB_FIRST ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
    endfunction

    // Operands are extended one bit past ACC_WIDTH so overflow shows as a sign-bit mismatch
    always_comb begin
        w_ext  = {{WIDTH{w_q[WIDTH-1]}}, w_q};
        d_ext  = {{WIDTH{d_q[WIDTH-1]}}, d_q};
        prod   = w_ext * d_ext;
        acc_x  = {acc_q[ACC_WIDTH-1], acc_q};
        prod_x = {{(XW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        d_x    = {{(XW-WIDTH){d_q[WIDTH-1]}}, d_q};
        arith  = (op_q == OP_MAC) || (op_q == OP_ADD) || (op_q == OP_SUB);
        sum_x  = acc_x;
        res    = acc_q;
        case (op_q)
            OP_MUL:  res = prod_x[ACC_WIDTH-1:0];
            OP_MAC:  sum_x = acc_x + prod_x;
            OP_ADD:  sum_x = acc_x + d_x;
            OP_SUB:  sum_x = acc_x - d_x;
            OP_ACT:  res = acc_q[ACC_WIDTH-1] ? '0 : acc_q;
            OP_CLR:  res = '0;
            default: res = acc_q;
        endcase
        ovf_hit = arith && (sum_x[XW-1] != sum_x[XW-2]);
        if (arith) begin
            res = sum_x[ACC_WIDTH-1:0];
`ifdef PERCEPT_SAT_EN
            if (ovf_hit) begin
                res = sum_x[XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        w_d     = w_q;
        d_d     = d_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_vld) begin
                    op_d    = opcode;
                    w_d     = shin(w_q, rx);
                    cnt_d   = CW'(1);
                    state_d = S_SHIFT_W;
                end
            end
            S_SHIFT_W: begin
                if (rx_vld) begin
                    w_d = shin(w_q, rx);
                    if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SHIFT_D;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_SHIFT_D: begin
                if (rx_vld) begin
                    d_d = shin(d_q, rx);
                    if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_EXEC: begin
                acc_d = res;
                if (op_q == OP_CLR) begin
                    ovf_d = 1'b0;
                end else if (ovf_hit) begin
                    ovf_d = 1'b1;
                end
                if (op_q == OP_READ) begin
                    sh_d    = acc_q;
                    state_d = S_SHIFT_OUT;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SHIFT_OUT: begin
                sh_d = MSB_FIRST ? {sh_q[ACC_WIDTH-2:0], 1'b0}
                                 : {1'b0, sh_q[ACC_WIDTH-1:1]};
                if (cnt_q == A_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            w_q     <= '0;
            d_q     <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            w_q     <= w_d;
            d_q     <= d_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign tx_vld = (state_q == S_SHIFT_OUT);
    assign tx     = tx_vld & (MSB_FIRST ? sh_q[ACC_WIDTH-1] : sh_q[0]);
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign acc    = acc_q;
endmodule

// File: tb/tb_percept_mac_serial.sv
// Bench for percept_mac_serial: frame-level model plus per-cycle output compare.
module tb_percept_mac_serial;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rx_m, rx_l, vld_a, rx_b, vld_b;
    logic [2:0]  op_a, op_b;
    logic        tx_m, txv_m, busy_m, done_m, ovf_m;
    logic        tx_l, txv_l, busy_l, done_l, ovf_l;
    logic        tx_b, txv_b, busy_b, done_b, ovf_b;
    logic [63:0] acc_m, acc_l;
    logic [15:0] acc_b;

    percept_mac_serial #(.WIDTH(32), .ACC_WIDTH(64), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .rx(rx_m), .rx_vld(vld_a), .opcode(op_a),
        .tx(tx_m), .tx_vld(txv_m), .acc(acc_m), .busy(busy_m), .done(done_m), .ovf(ovf_m));
    percept_mac_serial #(.WIDTH(32), .ACC_WIDTH(64), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .rx(rx_l), .rx_vld(vld_a), .opcode(op_a),
        .tx(tx_l), .tx_vld(txv_l), .acc(acc_l), .busy(busy_l), .done(done_l), .ovf(ovf_l));
    percept_mac_serial #(.WIDTH(8), .ACC_WIDTH(16), .MSB_FIRST(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_vld(vld_b), .opcode(op_b),
        .tx(tx_b), .tx_vld(txv_b), .acc(acc_b), .busy(busy_b), .done(done_b), .ovf(ovf_b));

`ifdef PERCEPT_SAT_EN
    localparam logic [15:0] W8_OVF_ACC = 16'h7FFF;
`else
    localparam logic [15:0] W8_OVF_ACC = 16'h8000;
`endif

    // Model state: index 0 = 32-bit pair, index 1 = 8-bit unit
    logic signed [127:0] m_acc [2];
    bit m_ovf [2];
    bit e_busy [2];
    bit e_done [2];
    bit e_txv [2];
    bit e_tx_m [2];
    bit e_tx_l;
    bit chk_en = 1'b0;
    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [63:0] cap_m, cap_l;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk64(name, {63'd0, act}, {63'd0, exp});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk64("acc_msb", acc_m, m_acc[0][63:0]);
            chk1("busy_msb", busy_m, e_busy[0]);
            chk1("done_msb", done_m, e_done[0]);
            chk1("ovf_msb", ovf_m, m_ovf[0]);
            chk1("txv_msb", txv_m, e_txv[0]);
            chk1("tx_msb", tx_m, e_tx_m[0]);
            chk64("acc_lsb", acc_l, m_acc[0][63:0]);
            chk1("busy_lsb", busy_l, e_busy[0]);
            chk1("done_lsb", done_l, e_done[0]);
            chk1("ovf_lsb", ovf_l, m_ovf[0]);
            chk1("txv_lsb", txv_l, e_txv[0]);
            chk1("tx_lsb", tx_l, e_tx_l);
            chk64("acc_w8", {48'd0, acc_b}, {48'd0, m_acc[1][15:0]});
            chk1("busy_w8", busy_b, e_busy[1]);
            chk1("done_w8", done_b, e_done[1]);
            chk1("ovf_w8", ovf_b, m_ovf[1]);
            chk1("txv_w8", txv_b, e_txv[1]);
            chk1("tx_w8", tx_b, e_tx_m[1]);
        end
    end

    always @(negedge clk) begin
        if (busy_m) busy_cnt++;
        if (done_m) done_cnt++;
        if (txv_m) cap_m <= {cap_m[62:0], tx_m};
        if (txv_l) cap_l <= {tx_l, cap_l[63:1]};
    end

    task automatic model_exec(input logic [2:0] op, input logic signed [127:0] w,
                              input logic signed [127:0] d, input int accw,
                              inout logic signed [127:0] a, inout bit ov);
        logic signed [127:0] r, m, maxv, minv, one;
        one  = 128'sd1;
        m    = one <<< accw;
        maxv = (m >>> 1) - one;
        minv = -(m >>> 1);
        case (op)
            3'd1:    r = w * d;
            3'd2:    r = a + w * d;
            3'd3:    r = a + d;
            3'd4:    r = a - d;
            3'd5:    r = (a < 0) ? 128'sd0 : a;
            3'd7:    begin r = 128'sd0; ov = 1'b0; end
            default: r = a;
        endcase
        if ((op == 3'd2 || op == 3'd3 || op == 3'd4) && (r > maxv || r < minv)) begin
            ov = 1'b1;
`ifdef PERCEPT_SAT_EN
            r = (r > maxv) ? maxv : minv;
`else
            r = (r > maxv) ? r - m : r + m;
`endif
        end
        a = r;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = '0; m_ovf[i] = 0; e_busy[i] = 0;
            e_done[i] = 0; e_txv[i] = 0; e_tx_m[i] = 0;
        end
        e_tx_l = 0;
    endtask

    task automatic do_reset();
        vld_a = 0; vld_b = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    // Drives one frame from posedge+1 and tracks expected outputs edge by edge
    task automatic send_frame(input bit sb, input logic [2:0] op, input longint w,
                              input longint d, input bit gaps, input int abort_at);
        int n, accw, si, idx;
        logic [63:0] wb, db, word, snap;
        logic signed [127:0] ws, ds, a;
        bit ov;
        si = sb ? 1 : 0;
        n = sb ? 8 : 32;
        accw = sb ? 16 : 64;
        wb = w;
        db = d;
        for (int k = 0; k < 2 * n; k++) begin
            if (k == abort_at) begin
                do_reset();
                return;
            end
            if (gaps && k > 0 && $urandom_range(0, 2) == 0) begin
                vld_a = 0; vld_b = 0;
                repeat ($urandom_range(1, 5)) begin
                    op_a = 3'($urandom_range(0, 7));
                    op_b = 3'($urandom_range(0, 7));
                    @(posedge clk); #1;
                end
            end
            word = (k < n) ? wb : db;
            idx = (k < n) ? k : k - n;
            if (!sb) begin
                vld_a = 1;
                rx_m = word[n-1-idx];
                rx_l = word[idx];
                op_a = (k == 0) ? op : 3'($urandom_range(0, 7));
            end else begin
                vld_b = 1;
                rx_b = word[n-1-idx];
                op_b = (k == 0) ? op : 3'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
            e_busy[si] = 1;
        end
        // rx_vld held high through EXEC must be ignored
        rx_m = 1; rx_l = 1; rx_b = 1;
        @(posedge clk); #1;
        vld_a = 0; vld_b = 0;
        ws = 128'(w);
        ds = 128'(d);
        a = m_acc[si];
        ov = m_ovf[si];
        model_exec(op, ws, ds, accw, a, ov);
        m_acc[si] = a;
        m_ovf[si] = ov;
        if (op != 3'd6) begin
            e_busy[si] = 0;
            e_done[si] = 1;
        end else begin
            snap = m_acc[si][63:0];
            e_txv[si] = 1;
            for (int i = 0; i < accw; i++) begin
                e_tx_m[si] = snap[accw-1-i];
                if (!sb) e_tx_l = snap[i];
                @(posedge clk); #1;
            end
            e_txv[si] = 0; e_tx_m[si] = 0; e_tx_l = 0;
            e_busy[si] = 0;
            e_done[si] = 1;
        end
        @(posedge clk); #1;
        e_done[si] = 0;
    endtask

    initial begin
        int b0, d0;
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int b0, d0;
        rst = 1; vld_a = 0; vld_b = 0; op_a = 0; op_b = 0;
        rx_m = 0; rx_l = 0; rx_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        chk64("reset_acc", acc_m, 64'd0);
        chk1("reset_busy", busy_m, 1'b0);

        b0 = busy_cnt; d0 = done_cnt;
        send_frame(0, 3'd1, 2000, 1000, 0, -1);
        chk64("mul_acc", acc_m, 64'd2000000);
        chk64("mul_model", m_acc[0][63:0], 64'd2000000);
        chk64("mul_busy_cycles", 64'(busy_cnt - b0), 64'd64);
        chk64("mul_done_cycles", 64'(done_cnt - d0), 64'd1);

        send_frame(0, 3'd2, -3, 1000, 0, -1);
        chk64("mac_acc", acc_m, 64'd1997000);
        chk1("mac_ovf", ovf_m, 1'b0);

        send_frame(0, 3'd7, 0, 0, 0, -1);
        send_frame(0, 3'd4, 0, 5, 0, -1);
        chk64("sub_acc", acc_m, 64'hFFFF_FFFF_FFFF_FFFB);
        send_frame(0, 3'd5, 0, 0, 0, -1);
        chk64("act_neg", acc_m, 64'd0);
        send_frame(0, 3'd3, 0, 7, 0, -1);
        send_frame(0, 3'd5, 0, 0, 0, -1);
        chk64("act_pos", acc_m, 64'd7);

        send_frame(0, 3'd1, 2000, 1000, 0, -1);
        send_frame(0, 3'd6, 0, 0, 0, -1);
        chk64("read_msb_word", cap_m, 64'h0000_0000_001E_8480);
        chk64("read_lsb_word", cap_l, 64'h0000_0000_001E_8480);
        chk64("read_keeps_acc", acc_m, 64'd2000000);

        send_frame(0, 3'd7, 0, 0, 0, -1);
        send_frame(0, 3'd1, 2000, 1000, 1, -1);
        chk64("gap_mul", acc_m, 64'd2000000);
        send_frame(0, 3'd2, -3, 1000, 1, -1);
        chk64("gap_mac", acc_m, 64'd1997000);

        send_frame(0, 3'd1, 55, 66, 0, 10);
        chk64("abort_acc", acc_m, 64'd0);
        chk1("abort_busy", busy_m, 1'b0);
        send_frame(0, 3'd1, 12, -7, 0, -1);
        chk64("after_abort", acc_m, 64'hFFFF_FFFF_FFFF_FFAC);
        send_frame(0, 3'd0, 9, 9, 0, -1);
        chk64("nop_acc", acc_m, 64'hFFFF_FFFF_FFFF_FFAC);

        send_frame(1, 3'd1, -128, -128, 0, -1);
        chk64("w8_mul", {48'd0, acc_b}, 64'd16384);
        send_frame(1, 3'd2, -128, -128, 0, -1);
        chk1("w8_ovf", ovf_b, 1'b1);
        chk64("w8_ovf_acc", {48'd0, acc_b}, {48'd0, W8_OVF_ACC});
        chk64("w8_model", {48'd0, m_acc[1][15:0]}, {48'd0, W8_OVF_ACC});
        send_frame(1, 3'd3, 0, 1, 0, -1);
        chk1("w8_ovf_sticky", ovf_b, 1'b1);
        send_frame(1, 3'd7, 0, 0, 0, -1);
        chk1("w8_clr_ovf", ovf_b, 1'b0);
        chk64("w8_clr_acc", {48'd0, acc_b}, 64'd0);
        send_frame(1, 3'd6, 0, 0, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
